// File: rtl/glove_pkg.sv
// Shared definitions for the glove sensor front end: sample width and the
// window-builder state encoding.
package glove_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_READY = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/sample_shift_row.sv
// One channel row of the sample window: a DEPTH-deep signed shift register.
// Element 0 is the oldest sample, element DEPTH-1 the newest.
module sample_shift_row
  import glove_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_shift_en,
  input  logic signed [DATA_W-1:0]        i_sample,
  output logic signed [DEPTH*DATA_W-1:0]  o_row
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  // Shift toward element 0 and insert the new sample at the newest slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int t = 0; t < DEPTH; t++) mem[t] <= '0;
    end else if (i_shift_en) begin
      for (int t = 0; t < DEPTH - 1; t++) mem[t] <= mem[t + 1];
      mem[DEPTH-1] <= i_sample;
    end
  end

  // Flatten the row so element t sits at bits [t*DATA_W +: DATA_W].
  always_comb begin
    o_row = '0;
    for (int t = 0; t < DEPTH; t++) o_row[t*DATA_W +: DATA_W] = mem[t];
  end

endmodule

// File: rtl/sample_window.sv
// Sliding sample window feeding the convolution stage.
// Collects CH-channel sample vectors into a CH x DEPTH window, fires o_start
// once the window is first full and then every HOP accepted samples, and holds
// the window frozen until the convolution stage reports i_conv_finished.
// Optional build macro SAMPLE_WINDOW_TIMEOUT_EN adds o_timeout and a 15-cycle
// wait watchdog that stands in for a missing i_conv_finished.
//
// Handshake: a sample transfers on a rising edge where i_valid && o_ready.
// o_ready depends only on the current state (never on i_valid). A sample
// offered together with i_flush is dropped; a sample offered while o_ready is
// low is ignored and need not be held by the producer.
module sample_window
  import glove_pkg::*;
#(
  parameter int CH    = 8,
  parameter int DEPTH = 5,
  parameter int HOP   = 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_valid,
  input  logic signed [CH*DATA_W-1:0]        i_sample,
  output logic                               o_ready,
  input  logic                               i_flush,
  output logic signed [CH*DEPTH*DATA_W-1:0]  o_data,
  output logic                               o_start,
  input  logic                               i_conv_finished,
  output logic [15:0]                        o_frames,
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
  output logic                               o_timeout,
`endif
  output state_t                             o_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] HOP_LAST  = CNT_W'(HOP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] hop_q, hop_d;
  logic             pend_q, pend_d;
  logic             accept;
  logic             done;
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
  logic [3:0]       wait_q, wait_d;
  logic             timeout_q, timeout_d;
`endif

  // State, counters and the deferred-flush flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_FILL;
      fill_q  <= '0;
      hop_q   <= '0;
      pend_q  <= 1'b0;
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
      wait_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hop_q   <= hop_d;
      pend_q  <= pend_d;
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next-state logic: fill, hop counting, issue, and wait for the consumer.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hop_d   = hop_q;
    pend_d  = pend_q;
    accept  = 1'b0;
    done    = 1'b0;
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
    wait_d    = '0;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_FILL: begin
        if (i_flush) begin
          fill_d = '0;
          hop_d  = '0;
        end else if (i_valid) begin
          accept = 1'b1;
          if (fill_q == FILL_LAST) begin
            fill_d  = '0;
            state_d = S_ISSUE;
          end else begin
            fill_d = fill_q + CNT_ONE;
          end
        end
      end
      S_READY: begin
        if (i_flush) begin
          fill_d  = '0;
          hop_d   = '0;
          state_d = S_FILL;
        end else if (i_valid) begin
          accept = 1'b1;
          if (hop_q == HOP_LAST) begin
            hop_d   = '0;
            state_d = S_ISSUE;
          end else begin
            hop_d = hop_q + CNT_ONE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        if (i_flush) pend_d = 1'b1;
      end
      S_WAIT: begin
        done = i_conv_finished;
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
        // The 15th wait cycle without a done pulse counts as done.
        if (!done) begin
          if (wait_q == 4'd14) begin
            done      = 1'b1;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
`endif
        if (done) begin
          state_d = (pend_q || i_flush) ? S_FILL : S_READY;
          pend_d  = 1'b0;
          fill_d  = '0;
          hop_d   = '0;
        end else if (i_flush) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Count issued windows; wraps naturally at 16 bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_frames <= '0;
    else if (state_q == S_ISSUE) o_frames <= o_frames + 16'd1;
  end

  assign o_ready = (state_q == S_FILL) || (state_q == S_READY);
  assign o_start = (state_q == S_ISSUE);
  assign o_state = state_q;
`ifdef SAMPLE_WINDOW_TIMEOUT_EN
  assign o_timeout = timeout_q;
`endif

  for (genvar ch = 0; ch < CH; ch++) begin : g_row
    sample_shift_row #(.DEPTH(DEPTH)) u_row (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_shift_en (accept),
      .i_sample   (i_sample[ch*DATA_W +: DATA_W]),
      .o_row      (o_data[ch*DEPTH*DATA_W +: DEPTH*DATA_W])
    );
  end

endmodule

// File: doc/sample_window.md
SAMPLE_WINDOW -- requirements
Module: sample_window

Interface
REQ-001 SHALL have parameter CH, default 8, number of sensor channels (window rows).
REQ-002 SHALL have parameter DEPTH, default 5, samples held per channel (window columns).
REQ-003 SHALL have parameter HOP, default 1, accepted samples between successive windows once full; legal range 1..DEPTH.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_valid, input, 1, i_sample carries a new sample vector.
REQ-007 SHALL have port i_sample, input, signed 16 x CH, one sample per channel.
REQ-008 SHALL have port o_ready, output, 1, block accepts a sample this cycle.
REQ-009 SHALL have port i_flush, input, 1, discard partial window.
REQ-010 SHALL have port o_data, output, signed 16 x CH*DEPTH, window; element ch*DEPTH+t, t=0 oldest, t=DEPTH-1 newest.
REQ-011 SHALL have port o_start, output, 1, one-cycle start pulse to the convolution stage.
REQ-012 SHALL have port i_conv_finished, input, 1, one-cycle done pulse from the convolution stage.
REQ-013 SHALL have port o_frames, output, 16, count of windows issued, wrapping.

Function
REQ-014 SHALL accept a sample on a rising edge where i_valid and o_ready are both high; a sample offered with o_ready low SHALL be ignored.
REQ-015 SHALL, on acceptance, shift each channel row one position toward t=0, dropping t=0 and writing i_sample[ch] at t=DEPTH-1.
REQ-016 SHALL implement states S_FILL, S_READY, S_ISSUE, S_WAIT.
REQ-017 SHALL, in S_FILL, count accepted samples; when DEPTH samples have been accepted it SHALL go to S_ISSUE.
REQ-018 SHALL, in S_READY, count accepted samples modulo HOP; on reaching HOP it SHALL go to S_ISSUE and clear the hop count.
REQ-019 SHALL assert o_start exactly during S_ISSUE (the cycle after the completing acceptance), then go to S_WAIT.
REQ-020 SHALL drive o_ready high only in S_FILL and S_READY; o_data SHALL be frozen throughout S_ISSUE and S_WAIT.
REQ-021 SHALL, in S_WAIT, on i_conv_finished go to S_READY; o_ready high the following cycle.
REQ-022 SHALL increment o_frames by one on each S_ISSUE cycle, wrapping 0xFFFF to 0x0000.
REQ-023 SHALL, on i_flush in S_FILL or S_READY, clear fill and hop counts and enter S_FILL; a sample offered in the same cycle SHALL be discarded.
REQ-024 SHALL, on i_flush in S_ISSUE or S_WAIT, latch a pending flush applied when i_conv_finished arrives (entering S_FILL instead of S_READY).
REQ-025 SHALL ignore i_conv_finished outside S_WAIT.
REQ-026 SHALL leave o_data contents unchanged on flush; only counts are cleared.

Reset
REQ-027 SHALL, on i_rst_n low, asynchronously clear o_data to 0, o_frames to 0, counts and pending flush to 0, o_start to 0, and enter S_FILL (o_ready=1 after release).
REQ-028 SHALL abandon any in-progress S_WAIT on reset mid-operation without issuing o_start.

Configuration
REQ-029 SHALL, with SAMPLE_WINDOW_TIMEOUT_EN defined, add output o_timeout (1 bit, sticky until reset) and a 4-bit wait counter; 15 cycles in S_WAIT without i_conv_finished SHALL set o_timeout and proceed as if i_conv_finished arrived.
REQ-030 SHALL, without SAMPLE_WINDOW_TIMEOUT_EN, omit o_timeout and the wait counter; S_WAIT persists indefinitely.

Structure
REQ-031 SHALL take DATA_W=16 and the state enumeration from shared package glove_pkg.
REQ-032 SHALL instantiate sub-module sample_shift_row once per channel (DEPTH-deep signed 16-bit shift register with shift enable and async reset).

Verification
REQ-033 SHALL cover: reset, then 5 accepted samples ch0=1..5 -> o_start one cycle after 5th, o_data[0..4]=1,2,3,4,5, o_frames=1.
REQ-034 SHALL cover: HOP=1, sample 6 after finished -> o_data[0..4]=2..6, second o_start, o_frames=2.
REQ-035 SHALL cover: i_valid held high in S_WAIT for 4 cycles -> o_ready=0, o_data unchanged, no samples lost from count.
REQ-036 SHALL cover: i_flush in S_WAIT, then i_conv_finished -> S_FILL; 4 samples produce no o_start, 5th does.
REQ-037 SHALL cover: i_flush and i_valid same cycle in S_READY -> sample discarded, fill count 0.
REQ-038 SHALL cover (SAMPLE_WINDOW_TIMEOUT_EN): no i_conv_finished for 15 cycles -> o_timeout=1, o_ready=1 next cycle.
